gzip_issue_queue: RTL and testbench

- Decoupling front-end for the multi-cycle generalized-zip core.
- Accepts tagged zip/unzip requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the core's start/rs1/rs2/rd/busy/done port set, captures the result on done, and presents it with its tag on a valid/ready response port.
- Sits directly upstream and downstream of the core, between decode/issue logic and the core.

---
 rtl/gzip_pkg.sv | 26 ++
 rtl/gzip_req_fifo.sv | 58 +++++
 rtl/gzip_issue_queue.sv | 121 ++++++++++++
 tb/tb_gzip_issue_queue.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gzip_pkg.sv
// Shared types and constants for the gzip issue front-end: FSM states,
// core latency and the request record layout carried through the FIFO.
package gzip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } gzip_state_t;

  // Core latency: edges from the start-sampling edge to the done edge.
  localparam int unsigned ZIP_LATENCY = 4;

  typedef struct packed {
    logic [31:0] rs1;
    logic [4:0]  rs2;
  } gzip_op_t;

  localparam int unsigned GZIP_OP_W = $bits(gzip_op_t);

  // A queued request is {rs1, rs2, tag}; its width depends on the tag width.
  function automatic int unsigned gzip_req_w(input int unsigned tag_w);
    return GZIP_OP_W + tag_w;
  endfunction

endpackage

// File: rtl/gzip_req_fifo.sv
// Synchronous request FIFO: power-of-two depth, wrapping pointers,
// full/empty from a count register with one extra bit.
module gzip_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 41
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gzip_issue_queue.sv
// Issue queue in front of the multi-cycle gzip core: buffers tagged requests,
// issues one at a time, holds one result. Option: GZIP_ISSUE_IDENTITY_BYPASS_EN.
module gzip_issue_queue
  import gzip_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             zip_reset,
  output logic             zip_start,
  output logic [31:0]      zip_rs1,
  output logic [4:0]       zip_rs2,
  input  logic [31:0]      zip_rd,
  input  logic             zip_busy,
  input  logic             zip_done
);

  localparam int unsigned REQ_W = gzip_req_w(TAG_W);

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REQ_W-1:0] fifo_head;
  gzip_op_t         head_op;
  logic [TAG_W-1:0] head_tag;

  gzip_state_t      state;
  logic [TAG_W-1:0] tag_q;
  logic             can_pop;
  logic             do_issue;
  logic             do_bypass;

  // zip_reset doubles as "still in reset", keeping req_ready low until it drops.
  assign req_ready = !fifo_full && !zip_reset;
  assign fifo_push = req_valid && req_ready;
  assign head_op   = fifo_head[REQ_W-1:TAG_W];
  assign head_tag  = fifo_head[TAG_W-1:0];
  assign fifo_pop  = do_issue || do_bypass;

  gzip_req_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(REQ_W)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (fifo_push),
    .push_data({req_rs1, req_rs2, req_tag}),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  always_comb begin
    can_pop = (state == IDLE) && !fifo_empty && !rsp_valid && !zip_reset;
`ifdef GZIP_ISSUE_IDENTITY_BYPASS_EN
    do_bypass = can_pop && (head_op.rs2[4:1] == 4'd0);
`else
    do_bypass = 1'b0;
`endif
    do_issue = can_pop && !do_bypass && !zip_busy;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      zip_reset <= 1'b1;
      zip_start <= 1'b0;
      zip_rs1   <= '0;
      zip_rs2   <= '0;
      tag_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
    end else begin
      zip_reset <= 1'b0;
      zip_start <= 1'b0;
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (do_issue) begin
            zip_rs1   <= head_op.rs1;
            zip_rs2   <= head_op.rs2;
            tag_q     <= head_tag;
            zip_start <= 1'b1;
            state     <= ISSUE;
          end else if (do_bypass) begin
            rsp_data  <= head_op.rs1;
            rsp_tag   <= head_tag;
            rsp_valid <= 1'b1;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (zip_done) begin
            rsp_data  <= zip_rd;
            rsp_tag   <= tag_q;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gzip_issue_queue.sv
// Self-checking bench for gzip_issue_queue: behavioural core, scoreboard of
// expected {tag, data} in request order, directed table plus random traffic.
module tb_gzip_issue_queue;
  import gzip_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;

`ifdef GZIP_ISSUE_IDENTITY_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_rs1 = '0;
  logic [4:0]       req_rs2 = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             zip_reset;
  logic             zip_start;
  logic [31:0]      zip_rs1;
  logic [4:0]       zip_rs2;
  logic [31:0]      zip_rd = '0;
  logic             zip_busy = 1'b0;
  logic             zip_done;
  logic             core_done = 1'b0;
  logic             spur_done = 1'b0;
  int unsigned      core_cnt = 0;

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned n_start = 0;
  int unsigned n_rsp = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [31:0]      rs1;
    logic [4:0]       rs2;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
  } vec_t;
  vec_t vt[7];

  assign zip_done = core_done | spur_done;
  always #5 clock = ~clock;

  gzip_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rs1  (req_rs1),
    .req_rs2  (req_rs2),
    .req_tag  (req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag),
    .zip_reset(zip_reset),
    .zip_start(zip_start),
    .zip_rs1  (zip_rs1),
    .zip_rs2  (zip_rs2),
    .zip_rd   (zip_rd),
    .zip_busy (zip_busy),
    .zip_done (zip_done)
  );

  function automatic logic [31:0] swap(input logic [31:0] x, input logic [31:0] ml,
                                       input logic [31:0] mr, input int unsigned n);
    return (x & ~(ml | mr)) | ((x << n) & ml) | ((x >> n) & mr);
  endfunction

  // Generalized zip: rs2[0] selects unzip, rs2[4:1] enable the 1/2/4/8 stages.
  function automatic logic [31:0] zip_model(input logic [31:0] a, input logic [4:0] c);
    logic [31:0] x;
    x = a;
    if (c[0]) begin
      if (c[1]) x = swap(x, 32'h44444444, 32'h22222222, 1);
      if (c[2]) x = swap(x, 32'h30303030, 32'h0c0c0c0c, 2);
      if (c[3]) x = swap(x, 32'h0f000f00, 32'h00f000f0, 4);
      if (c[4]) x = swap(x, 32'h00ff0000, 32'h0000ff00, 8);
    end else begin
      if (c[4]) x = swap(x, 32'h00ff0000, 32'h0000ff00, 8);
      if (c[3]) x = swap(x, 32'h0f000f00, 32'h00f000f0, 4);
      if (c[2]) x = swap(x, 32'h30303030, 32'h0c0c0c0c, 2);
      if (c[1]) x = swap(x, 32'h44444444, 32'h22222222, 1);
    end
    return x;
  endfunction

  function automatic bit is_bypass(input logic [4:0] c);
    return BYPASS && (c[4:1] == 4'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural core: samples start, answers ZIP_LATENCY edges later with a done pulse.
  always @(posedge clock) begin
    if (zip_reset) begin
      zip_busy  <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else begin
      core_done <= 1'b0;
      if (zip_start && !zip_busy) begin
        zip_busy <= 1'b1;
        core_cnt <= ZIP_LATENCY - 1;
        zip_rd   <= zip_model(zip_rs1, zip_rs2);
      end else if (zip_busy) begin
        if (core_cnt == 0) begin
          zip_busy  <= 1'b0;
          core_done <= 1'b1;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  // Scoreboard: accepted requests queue their expected result; responses must match in order.
  logic             prev_hold = 1'b0;
  logic [31:0]      prev_data = '0;
  logic [TAG_W-1:0] prev_tag = '0;
  always @(negedge clock) begin
    if (!resetn) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      exp_t e;
      if (zip_start) n_start++;
      if (rsp_valid && prev_hold) begin
        chk("rsp_stable_data", rsp_data, prev_data);
        chk("rsp_stable_tag", 32'(rsp_tag), 32'(prev_tag));
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rsp_tag_order", 32'(rsp_tag), 32'(e.tag));
          chk("rsp_data_model", rsp_data, e.data);
        end
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      prev_tag  = rsp_tag;
      if (req_valid && req_ready) begin
        e.tag  = req_tag;
        e.data = zip_model(req_rs1, req_rs2);
        exp_q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] rs1, input logic [4:0] rs2, input logic [TAG_W-1:0] tag);
    int unsigned g;
    g = 0;
    req_rs1 = rs1; req_rs2 = rs2; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && g < 200) begin step(); g++; end
    chk("push_accept", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [31:0] rs1, input logic [4:0] rs2,
                         input logic [TAG_W-1:0] tag, input logic [31:0] exp);
    int unsigned s0, k;
    s0 = n_start;
    rsp_ready = 1'b0;
    push(rs1, rs2, tag);
    k = 0;
    while (!rsp_valid && k < 40) begin step(); k++; end
    chk({nm, "_latency"}, k, is_bypass(rs2) ? 32'd1 : 32'd7);
    chk({nm, "_data"}, rsp_data, exp);
    chk({nm, "_tag"}, 32'(rsp_tag), 32'(tag));
    chk({nm, "_starts"}, n_start - s0, is_bypass(rs2) ? 32'd0 : 32'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, "_valid_clear"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || rsp_valid) && g < 400) begin step(); g++; end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, b0, g, quiet, acc_cnt, acc_core;
    logic acc;
    logic [TAG_W-1:0] rtag;

    vt[0] = '{32'h11223344, 5'b10000, 4'd3, 32'h11332244};
    vt[1] = '{32'h11223344, 5'b10001, 4'd4, 32'h11332244};
    vt[2] = '{32'hDEADBEEF, 5'b00001, 4'd5, 32'hDEADBEEF};
    vt[3] = '{32'hDEADBEEF, 5'b00000, 4'd6, 32'hDEADBEEF};
    vt[4] = '{32'h00000002, 5'b00010, 4'd7, 32'h00000004};
    vt[5] = '{32'h0000FFFF, 5'b11110, 4'd8, 32'h55555555};
    vt[6] = '{32'h55555555, 5'b11111, 4'd9, 32'h0000FFFF};

    // Reset
    resetn = 1'b0;
    repeat (3) step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_zip_reset", 32'(zip_reset), 32'd1);
    chk("rst_zip_start", 32'(zip_start), 32'd0);
    resetn = 1'b1;
    chk("rst_zip_reset_held", 32'(zip_reset), 32'd1);
    step();
    chk("rst_zip_reset_drop", 32'(zip_reset), 32'd0);
    chk("rst_req_ready_up", 32'(req_ready), 32'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_one($sformatf("vec%0d", i), vt[i].rs1, vt[i].rs2, vt[i].tag, vt[i].exp);
    end

    // Spurious done in IDLE
    s0 = n_start;
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (3) step();
    chk("spur_no_rsp", 32'(rsp_valid), 32'd0);
    chk("spur_no_start", n_start - s0, 32'd0);
    run_one("after_spur", 32'h0F0F1234, 5'b10100, 4'd2, zip_model(32'h0F0F1234, 5'b10100));

    // Backpressure and ordering
    rsp_ready = 1'b0;
    b0 = n_rsp;
    for (int i = 0; i < 5; i++) begin
      push(32'h01020304 * 32'(i + 1), 5'b10100 | 5'(i & 1), 4'(i));
    end
    req_rs1 = 32'hA5A55A5A; req_rs2 = 5'b01110; req_tag = 4'd5; req_valid = 1'b1;
    repeat (20) step();
    chk("bp_req_ready_low", 32'(req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_head_tag", 32'(rsp_tag), 32'd0);
    rsp_ready = 1'b1;
    g = 0;
    while (!req_ready && g < 60) begin step(); g++; end
    chk("bp_unblock", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    drain();
    chk("bp_count", n_rsp - b0, 32'd6);

    // Reset mid-operation
    rsp_ready = 1'b0;
    push(32'hCAFEF00D, 5'b10110, 4'd7);
    push(32'h0BADF00D, 5'b01010, 4'd8);
    g = 0;
    while (!zip_start && g < 20) begin step(); g++; end
    chk("rmid_start_seen", 32'(zip_start), 32'd1);
    step();
    step();
    resetn = 1'b0;
    step();
    chk("rmid_req_ready", 32'(req_ready), 32'd0);
    chk("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rmid_zip_reset", 32'(zip_reset), 32'd1);
    resetn = 1'b1;
    step();
    s0 = n_start;
    quiet = 0;
    rsp_ready = 1'b1;
    repeat (20) begin
      step();
      if (rsp_valid) quiet++;
    end
    rsp_ready = 1'b0;
    chk("rmid_no_rsp", quiet, 32'd0);
    chk("rmid_fifo_empty", n_start - s0, 32'd0);
    run_one("post_reset", 32'h11223344, 5'b10000, 4'd3, 32'h11332244);

    // Random traffic against the scoreboard
    b0 = n_rsp;
    s0 = n_start;
    acc_cnt = 0;
    acc_core = 0;
    rtag = '0;
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_rs1   = $urandom;
      req_rs2   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom);
      req_tag   = rtag;
      rsp_ready = ($urandom_range(0, 3) != 0);
      acc = req_valid && req_ready;
      if (acc) begin
        acc_cnt++;
        if (!is_bypass(req_rs2)) acc_core++;
      end
      step();
      if (acc) rtag = rtag + 4'd1;
    end
    req_valid = 1'b0;
    drain();
    chk("rnd_rsp_count", n_rsp - b0, acc_cnt);
    chk("rnd_start_count", n_start - s0, acc_core);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
